ext_bus_arbiter: RTL and testbench
==================================

// Module: ext_bus_arbiter
// PURPOSE
//  Arbitrates the Eighty_Twos chip's single external 8-bit memory/IO bus between two requesters:
//   - the CPU core's bus unit;
//   - the host/debug loader, which preloads programs and reads back results.
//  Sequences each transaction with a setup/strobe/ready handshake. Terminates stalled cycles by timeout.
//  Sits between the CPU core, the loader and the GPIO pad mapping: ext_rdata/ext_ready come from gpi,
//  and the ext_* outputs drive gpo.
// PARAMETERS
//  TIMEOUT  15  max cycles spent in STROBE waiting for ext_ready before an error completion (>=1)
//  AW       16  address width
// PORTS
//  clk        in   1   system clock; all logic on posedge
//  nrst       in   1   asynchronous active-low reset
//  cs         in   1   chip select; 0 = no new grants (in-flight transaction still completes)
//  cpu_req    in   1   CPU requests a bus cycle; held until cpu_ack
//  cpu_we     in   1   1 = write, 0 = read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   8   CPU write data
//  cpu_ack    out  1   one-cycle completion pulse to the CPU
//  host_req   in   1   host requests a bus cycle; held until host_ack
//  host_we    in   1   1 = write, 0 = read
//  host_addr  in   AW  host address
//  host_wdata in   8   host write data
//  host_ack   out  1   one-cycle completion pulse to the host
//  rdata      out  8   read data, shared by both requesters; valid in the ack cycle
//  err        out  1   ack cycle ended by timeout
//  ext_addr   out  AW  external address
//  ext_wdata  out  8   external write data
//  ext_we     out  1   external write enable
//  ext_oe     out  1   1 = chip drives the data pads (write transaction in SETUP/STROBE)
//  ext_strobe out  1   transaction strobe
//  ext_rdata  in   8   external read data
//  ext_ready  in   1   external device ready/complete (gpi[23])
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=HOST (so the CPU wins the first tie). Reset values of outputs:
//   - all outputs 0, except rdata=8'h00;
//   - timeout counter 0.
//  FSM IDLE -> SETUP -> STROBE -> DONE -> IDLE. All outputs are registered.
//  IDLE: if cs=1 and any req is high, grant on this edge and go to SETUP.
//   - only one req high: grant it;
//   - both high: grant the one that is not last_grant, then update last_grant (round-robin).
//  SETUP (1 cycle):
//   - ext_addr, ext_wdata and ext_we are latched from the granted requester and held until DONE exits;
//   - ext_oe=ext_we; ext_strobe=0.
//  STROBE:
//   - ext_strobe=1 and the counter increments each cycle;
//   - ext_ready sampled 1 -> DONE, rdata<=ext_rdata (held unchanged for writes), err<=0;
//   - counter reaches TIMEOUT with ext_ready=0 -> DONE, rdata<=8'hFF, err<=1.
//  DONE (1 cycle):
//   - the granted requester's ack=1;
//   - ext_strobe=0, ext_oe=0, counter cleared; then IDLE.
//  Latency:
//   - req high before edge E0 in IDLE: SETUP after E0, STROBE after E1;
//   - ready high at E2 gives ack in the cycle after E2, i.e. at least 3 cycles;
//   - minimum IDLE gap between transactions is 1 cycle.
//  Other boundary cases:
//   - req still high in IDLE after its ack is a new transaction (back-to-back allowed);
//   - req dropped mid-transaction: the transaction still completes and ack is still issued;
//   - cs falling mid-transaction: the transaction completes; no new grant while cs=0;
//   - ext_ready high during SETUP is ignored, and only sampled in STROBE;
//   - nrst low in any state: immediate return to reset values, with no ack for the aborted cycle;
//   - at most one ack high per cycle; cpu_ack and host_ack are never both high.
// TESTING
//  T1 CPU read:
//   - stimulus: cpu_req, addr 16'h0012, ext_rdata=8'h45, ready asserted in first STROBE cycle;
//   - required: cpu_ack 3 cycles after req; rdata=8'h45, err=0.
//  T2 host write:
//   - stimulus: host_req, we=1, addr 16'h0100, wdata=8'hA5;
//   - required: ext_oe=1 and ext_wdata=8'hA5 throughout SETUP/STROBE; host_ack pulse.
//  T3 simultaneous requests, both held high:
//   - required grant order CPU, HOST, CPU, HOST; acks alternate, never both high.
//  T4 timeout (TIMEOUT=15):
//   - stimulus: ext_ready held 0;
//   - required: ack after 15 STROBE cycles with err=1, rdata=8'hFF; the next transaction has err=0.
//  T5 cs:
//   - cs=0 with cpu_req high gives no grant for 10 cycles;
//   - cs dropped during STROBE: the transaction still completes with ack.
//  T6 reset mid-transaction:
//   - stimulus: nrst pulsed low in STROBE;
//   - required: all outputs immediately at reset values, no ack; the next request proceeds normally.

Source files
------------

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: shares the single external 8-bit memory/IO bus between the
// CPU bus unit and the host/debug loader. Each transaction runs
// IDLE -> SETUP -> STROBE -> DONE with round-robin arbitration on ties and a
// bounded wait for ext_ready in STROBE. Every output comes straight from a flop.
module ext_bus_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int AW      = 16
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          cs,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_wdata,
   output logic          host_ack,
   output logic [7:0]    rdata,
   output logic          err,
   output logic [AW-1:0] ext_addr,
   output logic [7:0]    ext_wdata,
   output logic          ext_we,
   output logic          ext_oe,
   output logic          ext_strobe,
   input  logic [7:0]    ext_rdata,
   input  logic          ext_ready
);

   // counter must be able to hold the value TIMEOUT itself
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_TMO  = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t          state_q,      state_d;
   logic            last_host_q,  last_host_d;   // 1 = host held the last grant
   logic            gnt_host_q,   gnt_host_d;    // owner of the current transaction
   logic [CW-1:0]   cnt_q,        cnt_d;
   logic            cpu_ack_q,    cpu_ack_d;
   logic            host_ack_q,   host_ack_d;
   logic [7:0]      rdata_q,      rdata_d;
   logic            err_q,        err_d;
   logic [AW-1:0]   ext_addr_q,   ext_addr_d;
   logic [7:0]      ext_wdata_q,  ext_wdata_d;
   logic            ext_we_q,     ext_we_d;
   logic            ext_oe_q,     ext_oe_d;
   logic            ext_strobe_q, ext_strobe_d;

   logic            pick_host_s;
   logic            sel_we_s;
   logic [CW-1:0]   cnt_inc_s;

   assign cnt_inc_s = cnt_q + CNT_ONE;

   // next-state and next-output logic for the transaction sequencer
   always_comb begin
      state_d      = state_q;
      last_host_d  = last_host_q;
      gnt_host_d   = gnt_host_q;
      cnt_d        = cnt_q;
      cpu_ack_d    = 1'b0;
      host_ack_d   = 1'b0;
      rdata_d      = rdata_q;
      err_d        = err_q;
      ext_addr_d   = ext_addr_q;
      ext_wdata_d  = ext_wdata_q;
      ext_we_d     = ext_we_q;
      ext_oe_d     = ext_oe_q;
      ext_strobe_d = ext_strobe_q;
      pick_host_s  = 1'b0;
      sel_we_s     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            err_d = 1'b0;
            if (cs && (cpu_req || host_req)) begin
               // on a tie the requester that did not win last time goes first
               if (cpu_req && host_req) begin
                  pick_host_s = ~last_host_q;
               end else begin
                  pick_host_s = host_req;
               end
               sel_we_s     = pick_host_s ? host_we : cpu_we;
               state_d      = ST_SETUP;
               gnt_host_d   = pick_host_s;
               last_host_d  = pick_host_s;
               ext_addr_d   = pick_host_s ? host_addr  : cpu_addr;
               ext_wdata_d  = pick_host_s ? host_wdata : cpu_wdata;
               ext_we_d     = sel_we_s;
               ext_oe_d     = sel_we_s;
               ext_strobe_d = 1'b0;
               cnt_d        = CNT_ZERO;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SETUP: begin
            // address/data have been stable for one cycle; open the strobe
            state_d      = ST_STROBE;
            ext_strobe_d = 1'b1;
         end

         ST_STROBE: begin
            if (ext_ready) begin
               state_d      = ST_DONE;
               cnt_d        = cnt_inc_s;
               if (ext_we_q) begin
                  rdata_d = rdata_q;
               end else begin
                  rdata_d = ext_rdata;
               end
               err_d        = 1'b0;
               cpu_ack_d    = ~gnt_host_q;
               host_ack_d   = gnt_host_q;
               ext_strobe_d = 1'b0;
               ext_oe_d     = 1'b0;
            end else if (cnt_inc_s == CNT_TMO) begin
               // device never answered: complete with an error marker
               state_d      = ST_DONE;
               cnt_d        = cnt_inc_s;
               rdata_d      = 8'hFF;
               err_d        = 1'b1;
               cpu_ack_d    = ~gnt_host_q;
               host_ack_d   = gnt_host_q;
               ext_strobe_d = 1'b0;
               ext_oe_d     = 1'b0;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end

         ST_DONE: begin
            state_d      = ST_IDLE;
            cnt_d        = CNT_ZERO;
            err_d        = 1'b0;
            ext_we_d     = 1'b0;
            ext_oe_d     = 1'b0;
            ext_strobe_d = 1'b0;
         end

         default: begin
            state_d      = ST_IDLE;
            cnt_d        = CNT_ZERO;
            err_d        = 1'b0;
            ext_we_d     = 1'b0;
            ext_oe_d     = 1'b0;
            ext_strobe_d = 1'b0;
         end
      endcase
   end

   // state and output registers; reset aborts any cycle without an ack
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         last_host_q  <= 1'b1;
         gnt_host_q   <= 1'b0;
         cnt_q        <= CNT_ZERO;
         cpu_ack_q    <= 1'b0;
         host_ack_q   <= 1'b0;
         rdata_q      <= 8'h00;
         err_q        <= 1'b0;
         ext_addr_q   <= {AW{1'b0}};
         ext_wdata_q  <= 8'h00;
         ext_we_q     <= 1'b0;
         ext_oe_q     <= 1'b0;
         ext_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_host_q  <= last_host_d;
         gnt_host_q   <= gnt_host_d;
         cnt_q        <= cnt_d;
         cpu_ack_q    <= cpu_ack_d;
         host_ack_q   <= host_ack_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         ext_addr_q   <= ext_addr_d;
         ext_wdata_q  <= ext_wdata_d;
         ext_we_q     <= ext_we_d;
         ext_oe_q     <= ext_oe_d;
         ext_strobe_q <= ext_strobe_d;
      end
   end

   assign cpu_ack    = cpu_ack_q;
   assign host_ack   = host_ack_q;
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign ext_addr   = ext_addr_q;
   assign ext_wdata  = ext_wdata_q;
   assign ext_we     = ext_we_q;
   assign ext_oe     = ext_oe_q;
   assign ext_strobe = ext_strobe_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: randomized traffic from two requester agents and a
// random-latency device, checked every cycle against a transaction schedule
// model (grant decision + cycle offsets within a transaction).
module tb_ext_bus_arbiter;

   localparam int TIMEOUT = 15;
   localparam int AW      = 16;
   localparam int NCYC    = 4000;

   logic          clk = 1'b0;
   logic          nrst;
   logic          cs;
   logic          cpu_req, cpu_we, host_req, host_we;
   logic [AW-1:0] cpu_addr, host_addr;
   logic [7:0]    cpu_wdata, host_wdata;
   logic          cpu_ack, host_ack, err, ext_we, ext_oe, ext_strobe, ext_ready;
   logic [7:0]    rdata, ext_wdata, ext_rdata;
   logic [AW-1:0] ext_addr;

   ext_bus_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
      .clk(clk), .nrst(nrst), .cs(cs),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
      .rdata(rdata), .err(err),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_oe(ext_oe), .ext_strobe(ext_strobe),
      .ext_rdata(ext_rdata), .ext_ready(ext_ready)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int n_rst   = 0;
   int n_tmo   = 0;
   int cs_off  = 0;

   // requester agents: index 0 = CPU, 1 = host
   logic          a_req   [2];
   logic          a_wait  [2];
   int            a_gap   [2];
   logic          a_we    [2];
   logic [AW-1:0] a_addr  [2];
   logic [7:0]    a_wdata [2];

   // reference model: one transaction described by its schedule
   bit            m_busy;
   int            m_k;        // 0 = setup cycle, 1..m_n = strobe cycles, m_n+1 = ack cycle
   int            m_n;
   int            m_L;        // strobe cycle in which the device answers
   bit            m_tmo;
   bit            m_host;
   bit            m_last_host;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_wdata;
   logic [7:0]    m_rdata;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy      = 1'b0;
      m_k         = 0;
      m_n         = 0;
      m_last_host = 1'b1;
      m_rdata     = 8'h00;
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_cpu_ack"},  32'(cpu_ack),    32'd0);
      check_val({tag, "_host_ack"}, 32'(host_ack),   32'd0);
      check_val({tag, "_rdata"},    32'(rdata),      32'd0);
      check_val({tag, "_err"},      32'(err),        32'd0);
      check_val({tag, "_ext_addr"}, 32'(ext_addr),   32'd0);
      check_val({tag, "_ext_wdat"}, 32'(ext_wdata),  32'd0);
      check_val({tag, "_ext_we"},   32'(ext_we),     32'd0);
      check_val({tag, "_ext_oe"},   32'(ext_oe),     32'd0);
      check_val({tag, "_strobe"},   32'(ext_strobe), 32'd0);
   endtask

   task automatic check_cycle();
      bit act, stb, ack;
      act = m_busy && (m_k <= m_n);
      stb = m_busy && (m_k >= 1) && (m_k <= m_n);
      ack = m_busy && (m_k == m_n + 1);
      check_val("cpu_ack",    32'(cpu_ack),    32'(ack && !m_host));
      check_val("host_ack",   32'(host_ack),   32'(ack && m_host));
      check_val("ext_strobe", 32'(ext_strobe), 32'(stb));
      check_val("ext_oe",     32'(ext_oe),     32'(act && m_we));
      check_val("rdata",      32'(rdata),      32'(m_rdata));
      check_val("err",        32'(err),        32'(ack && m_tmo));
      if (act) begin
         check_val("ext_addr",  32'(ext_addr),  32'(m_addr));
         check_val("ext_wdata", 32'(ext_wdata), 32'(m_wdata));
         check_val("ext_we",    32'(ext_we),    32'(m_we));
      end
   endtask

   task automatic new_req(input int i);
      a_req[i]   = 1'b1;
      a_we[i]    = 1'($urandom_range(0, 1));
      a_addr[i]  = AW'($urandom);
      a_wdata[i] = 8'($urandom);
   endtask

   // choose this cycle's inputs, then advance the model across the coming edge
   task automatic drive_and_step();
      logic acked;
      bit   stb;
      for (int i = 0; i < 2; i++) begin
         acked = (i == 0) ? cpu_ack : host_ack;
         if (acked && (a_req[i] || a_wait[i])) begin
            a_wait[i] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
               new_req(i);
            end else begin
               a_req[i] = 1'b0;
               a_gap[i] = $urandom_range(0, 5);
            end
         end else if (a_req[i]) begin
            // occasionally withdraw the request once it has been granted
            if (m_busy && (m_host == (i == 1)) && ($urandom_range(0, 7) == 0)) begin
               a_req[i]  = 1'b0;
               a_wait[i] = 1'b1;
            end
         end else if (!a_wait[i]) begin
            if (a_gap[i] > 0) a_gap[i]--;
            else new_req(i);
         end
      end
      cpu_req = a_req[0]; cpu_we = a_we[0]; cpu_addr = a_addr[0]; cpu_wdata = a_wdata[0];
      host_req = a_req[1]; host_we = a_we[1]; host_addr = a_addr[1]; host_wdata = a_wdata[1];

      if (cs_off > 0) begin
         cs = 1'b0;
         cs_off--;
      end else if ($urandom_range(0, 59) == 0) begin
         cs = 1'b0;
         cs_off = $urandom_range(10, 20);
      end else begin
         cs = 1'b1;
      end

      stb = m_busy && (m_k >= 1) && (m_k <= m_n);
      ext_ready = stb ? (m_k == m_L) : 1'($urandom_range(0, 1));
      ext_rdata = 8'($urandom);

      if (m_busy) begin
         if (m_k == m_n) begin
            if (m_tmo) m_rdata = 8'hFF;
            else if (!m_we) m_rdata = ext_rdata;
         end
         if (m_k == m_n + 1) m_busy = 1'b0;
         else m_k++;
      end else if (cs && (cpu_req || host_req)) begin
         m_host      = (cpu_req && host_req) ? !m_last_host : host_req;
         m_last_host = m_host;
         m_we        = m_host ? host_we    : cpu_we;
         m_addr      = m_host ? host_addr  : cpu_addr;
         m_wdata     = m_host ? host_wdata : cpu_wdata;
         if ($urandom_range(0, 3) == 0) m_L = TIMEOUT + 1;
         else m_L = $urandom_range(1, TIMEOUT);
         m_tmo  = (m_L > TIMEOUT);
         if (m_tmo) n_tmo++;
         m_n    = m_tmo ? TIMEOUT : m_L;
         m_k    = 0;
         m_busy = 1'b1;
      end
   endtask

   initial begin
      nrst = 1'b1; cs = 1'b0; ext_ready = 1'b0; ext_rdata = 8'h00;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 8'h00;
      for (int i = 0; i < 2; i++) begin
         a_req[i] = 1'b0; a_wait[i] = 1'b0; a_gap[i] = $urandom_range(0, 3);
         a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = 8'h00;
      end
      model_reset();
      #2 nrst = 1'b0;
      @(negedge clk);
      check_reset("por");
      @(negedge clk);
      nrst = 1'b1;
      drive_and_step();

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (m_busy && (m_k >= 1) && (m_k <= m_n) &&
             (((n_rst == 0) && (cyc > NCYC / 2)) || ($urandom_range(0, 299) == 0))) begin
            n_rst++;
            nrst = 1'b0;
            #1;
            check_reset("rst_async");
            model_reset();
            a_wait[0] = 1'b0;
            a_wait[1] = 1'b0;
            @(negedge clk);
            check_reset("rst_hold");
            nrst = 1'b1;
         end else begin
            check_cycle();
         end
         drive_and_step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
